// File: rtl/mac_pipe_sequencer.sv
// ============================================================================
// mac_pipe_sequencer
// ----------------------------------------------------------------------------
// Purpose:
//   Sequences a two-stage pipelined multiply/accumulate datapath over a vector
//   of `len` operand pairs. It issues one operand read per advancing cycle,
//   walks the operand index, and moves a two-bit valid chain (v1 for the
//   multiplier stage, v2 for the adder stage) that produces the stage load
//   enables. When operands are unavailable (`can_mult` low) the whole pipe
//   freezes. After the last read the pipe drains for two cycles, and then
//   `done` pulses for one cycle.
//
// Timing without stalls (start sampled in cycle 0, L = len):
//   acc_clr  : cycle 0
//   rd_en    : cycles 1..L      (rd_addr = 0..L-1)
//   ld_mult  : cycles 2..L+1
//   ld_add   : cycles 3..L+2
//   done     : cycle  L+3
//   Each stall cycle adds one cycle to every later event.
//
// Parameters:
//   CNT_W      width of len / rd_addr; longest vector is 2^CNT_W-1 pairs
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous, active-high reset
//   start        in   begin an operation (only honoured in IDLE)
//   len          in   number of operand pairs, sampled with start
//   can_mult     in   operands readable this cycle; low stalls the pipe
//   rd_en        out  operand memory read strobe
//   rd_addr      out  operand index being read (holds when rd_en is low)
//   ld_mult      out  load multiplier stage register
//   ld_add       out  load adder/accumulator register
//   acc_clr      out  one-cycle accumulator clear at an accepted start
//   pipe_stall   out  pipe frozen this cycle
//   busy         out  operation in progress
//   done         out  one-cycle completion pulse
//   stall_cycles out  [15:0] saturating count of stalled issue cycles
//                     (present only when MAC_PIPE_PERF_CNT_EN is defined)
//
// Optional feature:
//   Define MAC_PIPE_PERF_CNT_EN to add the stall_cycles performance counter.
//   It clears on every accepted start, saturates at 16'hFFFF and holds its
//   value after done until the next accepted start.
// ============================================================================
module mac_pipe_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             can_mult,
    output logic             rd_en,
    output logic [CNT_W-1:0] rd_addr,
    output logic             ld_mult,
    output logic             ld_add,
    output logic             acc_clr,
    output logic             pipe_stall,
    output logic             busy,
    output logic             done
`ifdef MAC_PIPE_PERF_CNT_EN
    ,
    output logic [15:0]      stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] idx_q,       idx_d;
    logic [CNT_W-1:0] len_q,       len_d;
    logic [CNT_W-1:0] last_addr_q, last_addr_d;
    logic             v1_q,        v1_d;
    logic             v2_q,        v2_d;

    logic             last_issue;

    // The final read happens at idx == len_q-1. Switching to DRAIN there
    // (rather than comparing against len_q after the increment) lets
    // len = 2^CNT_W-1 work without the index ever wrapping.
    assign last_issue = (idx_q == (len_q - CNT_W'(1)));

    // Next-state and output decode. rd_addr shows the live index while
    // reading and otherwise replays the last address actually read, which is
    // why the last read address has its own register separate from idx.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        last_addr_d = last_addr_q;
        v1_d        = v1_q;
        v2_d        = v2_q;
        rd_en       = 1'b0;
        rd_addr     = last_addr_q;
        acc_clr     = 1'b0;
        pipe_stall  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        acc_clr = 1'b1;
                        len_d   = len;
                        idx_d   = '0;
                        state_d = ISSUE;
                    end else begin
                        // Empty vector: nothing to read or accumulate,
                        // just report completion.
                        state_d = DONE;
                    end
                end
            end

            ISSUE: begin
                busy = 1'b1;
                if (can_mult) begin
                    rd_en       = 1'b1;
                    rd_addr     = idx_q;
                    last_addr_d = idx_q;
                    v1_d        = 1'b1;
                    v2_d        = v1_q;
                    idx_d       = idx_q + CNT_W'(1);
                    if (last_issue) begin
                        state_d = DRAIN;
                    end
                end else begin
                    // Operands not ready: every stage holds its contents.
                    pipe_stall = 1'b1;
                end
            end

            DRAIN: begin
                // No more reads; the pipe always advances so the last two
                // operands finish flowing through regardless of can_mult.
                busy = 1'b1;
                v1_d = 1'b0;
                v2_d = v1_q;
                if (!v1_q) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stage enables follow the valid chain but are masked while the pipe is
    // frozen, so a stalled operand is not latched twice.
    assign ld_mult = v1_q && !pipe_stall;
    assign ld_add  = v2_q && !pipe_stall;

    // State and pipeline registers. Reset aborts any operation in flight and
    // throws away the valid chain so no stray loads or done follow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            last_addr_q <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            last_addr_q <= last_addr_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
        end
    end

`ifdef MAC_PIPE_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Stall counter: restarts on any accepted start (including an empty
    // vector), counts frozen issue cycles, and sticks at all-ones instead of
    // wrapping so an overflow is still visible as "very many".
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && start) begin
            stall_cnt_d = '0;
        end else if (pipe_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: doc/mac_pipe_sequencer.md
Name: mac_pipe_sequencer

Overview:
- Sequences the two-stage pipelined multiply/add datapath (mult stage, add/accumulate stage) over a vector of `len` operand pairs.
- Generates the operand-memory read addresses.
- Drives the stage load enables (`ld_mult`, `ld_add`) from a valid shift chain.
- Freezes the pipe while operands are unavailable, drains after the last issue, and pulses `done`.
- Sits between the top-level FSM (`start`/`done`) and the MAC datapath plus operand memories.

Parameters:
- CNT_W, 8: width of `len` and `rd_addr`; max vector length is 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a vector operation; sampled only in IDLE
- len  input  CNT_W  number of operand pairs; sampled with `start`
- can_mult  input  1  operands valid/readable this cycle; low = stall
- rd_en  output  1  operand memory read strobe
- rd_addr  output  CNT_W  operand index being read
- ld_mult  output  1  load multiplier stage register
- ld_add  output  1  load adder/accumulator register
- acc_clr  output  1  clear accumulator (one-cycle pulse)
- pipe_stall  output  1  pipe frozen this cycle
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - State = IDLE; idx = 0; v1 = v2 = 0.
  - All outputs 0, including `rd_addr`.
  - Reset mid-operation aborts immediately: no `done`, and the pipeline valids are discarded.
- States: IDLE, ISSUE, DRAIN, DONE. Internal registers: idx (CNT_W), len_q (CNT_W), v1/v2 (stage valid flags).
- IDLE:
  - `acc_clr` = `start` && (`len` != 0), combinational.
  - If `start` && `len` != 0: len_q <= `len`, idx <= 0, go to ISSUE.
  - If `start` && `len` == 0: go to DONE. No reads, no loads, no `acc_clr`.
- ISSUE:
  - `busy` = 1.
  - If `can_mult` = 1:
    - `rd_en` = 1, `rd_addr` = idx.
    - v1 <= 1, v2 <= v1, idx <= idx+1.
    - If idx == len_q-1, go to DRAIN.
  - If `can_mult` = 0:
    - `pipe_stall` = 1, `rd_en` = 0.
    - idx, v1 and v2 hold; `ld_mult` = `ld_add` = 0. The whole pipe freezes.
- Stage enables:
  - `ld_mult` = v1 && !`pipe_stall`.
  - `ld_add` = v2 && !`pipe_stall`.
  - Read data for issue at cycle t is latched by `ld_mult` at t+1 and accumulated by `ld_add` at t+2.
- DRAIN:
  - `busy` = 1; `can_mult` is ignored and the pipe always advances.
  - v1 <= 0, v2 <= v1.
  - Go to DONE when v1 == 0 and v2 == 0 after the update, i.e. exactly 2 cycles after the last issue.
- DONE:
  - `done` = 1 for one cycle, `busy` = 0, then go to IDLE.
  - `start` asserted in DONE is ignored.
- `start` asserted while not in IDLE is ignored; a new `len` is not sampled.
- Latency, no stalls, L = `len`, `start` sampled in cycle 0:
  - `acc_clr` in cycle 0.
  - `rd_en` in cycles 1..L.
  - `ld_mult` in cycles 2..L+1.
  - `ld_add` in cycles 3..L+2.
  - `done` in cycle L+3.
  - Each stall cycle in ISSUE adds exactly one cycle to all later events.
- `rd_addr` holds its last value when `rd_en` = 0; it is 0 after reset.
- idx never wraps: DRAIN is entered at idx == len_q-1, so L = 2^CNT_W-1 is legal.

Optional Feature:
- Macro: MAC_PIPE_PERF_CNT_EN.
- Defined:
  - Extra output `stall_cycles` [15:0] counts ISSUE cycles with `pipe_stall` = 1.
  - Cleared on an accepted `start`; saturates at 16'hFFFF; holds after `done` until the next accepted `start`; reset to 0.
- Not defined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then `start` with `len`=4, `can_mult`=1 constantly -> `acc_clr` at c0; `rd_en` at c1..c4 with `rd_addr` 0,1,2,3; `ld_mult` at c2..c5; `ld_add` at c3..c6; `done` at c7; `busy` high c1..c6.
- `len`=3, `can_mult` low in cycles 2 and 3 -> `rd_addr` 0 at c1, 1 at c4, 2 at c5; `pipe_stall` high c2..c3 with `ld_mult`/`ld_add` 0; `done` at c8. With MAC_PIPE_PERF_CNT_EN, `stall_cycles`=2.
- `start` with `len`=0 -> no `rd_en`/`acc_clr`/`ld_*`; `done` high the cycle after `start`; back to IDLE.
- `len`=5, `rst` asserted at c3 -> all outputs 0 at c4; no `done` ever; a new `start` with `len`=1 then completes normally (`done` 4 cycles after `start`).
- `start` re-asserted with `len`=9 during ISSUE and again during DONE of a `len`=2 run -> ignored; exactly 2 reads and one `done`.
- `len`=255 (CNT_W=8), no stalls -> `rd_addr` 0..254 with no wrap; `done` at c258.
